// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch slice: bus widths, chip-enable
// levels, PC step and the fetch FSM state encoding.
package if_fetch_ctrl_pkg;

    localparam int unsigned InstAddrWidth = 32;
    localparam int unsigned InstWidth     = 32;

    localparam logic                     ChipEnable  = 1'b1;
    localparam logic                     ChipDisable = 1'b0;
    localparam logic [InstWidth-1:0]     ZeroWord    = '0;
    localparam logic [InstAddrWidth-1:0] PcStep      = 32'd4;

    typedef enum logic [1:0] {
        FetchIdle = 2'b00,
        FetchRun  = 2'b01,
        FetchHalt = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_fifo.sv
// Two-entry {pc, inst} fetch queue with push/pop/flush. The head is read
// straight from storage and reads ZeroWord while the queue is empty.
module fetch_fifo
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [InstAddrWidth-1:0] push_pc,
    input  logic [InstWidth-1:0]     push_inst,
    output logic [1:0]               count,
    output logic                     full,
    output logic                     head_valid,
    output logic [InstAddrWidth-1:0] head_pc,
    output logic [InstWidth-1:0]     head_inst
);

    logic [InstAddrWidth-1:0] pc_q   [2];
    logic [InstWidth-1:0]     inst_q [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    // Occupancy flags, qualified handshakes and head read-out
    always_comb begin
        full       = (count >= 2'(DEPTH));
        head_valid = (count != 2'd0);
        do_pop     = pop & head_valid;
        do_push    = push & (~full | do_pop);
        head_pc    = head_valid ? pc_q[rd_ptr]   : ZeroWord;
        head_inst  = head_valid ? inst_q[rd_ptr] : ZeroWord;
    end

    // Storage, pointers and count; flush overrides any push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]   <= push_pc;
                inst_q[wr_ptr] <= push_inst;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the combinational ROM and
// feeds fetched {pc, inst} pairs into a 2-entry queue toward decode.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [InstAddrWidth-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned              FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [InstAddrWidth-1:0] redirect_pc,
    output logic                     rom_ce,
    output logic [InstAddrWidth-1:0] rom_addr,
    input  logic [InstWidth-1:0]     rom_inst,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [InstAddrWidth-1:0] if_pc,
    output logic [InstWidth-1:0]     if_inst
);

    fetch_state_e             state;
    logic [InstAddrWidth-1:0] pc;
    logic [1:0]               count;
    logic                     full;
    logic                     pop;
    logic                     space;
    logic                     push;

    // Handshake, fetch qualification and ROM drive
    always_comb begin
        pop      = if_valid & if_ready;
        space    = ~full | pop;
        push     = (state == FetchRun) & space & ~redirect_valid;
        rom_ce   = ((state == FetchRun) && space) ? ChipEnable : ChipDisable;
        rom_addr = pc;
    end

    // Fetch FSM; redirect never affects the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FetchIdle;
        end else begin
            case (state)
                FetchIdle: state <= halt ? FetchHalt : FetchRun;
                FetchRun:  if (halt)  state <= FetchHalt;
                FetchHalt: if (!halt) state <= FetchRun;
                default:   state <= FetchIdle;
            endcase
        end
    end

    // Program counter: redirect wins over sequential advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~32'h0000_0003;
        end else if (push) begin
            pc <= pc + PcStep;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_pc    (pc),
        .push_inst  (rom_inst),
        .count      (count),
        .full       (full),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_inst  (if_inst)
    );

endmodule
